// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master between two
// single-byte clients, with a post-write guard and a transaction timeout.
module i2c_bus_arbiter #(
   parameter int WAIT_MAX    = 250_000,
   parameter int TIMEOUT_MAX = 1_000_000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        wr0,
   input  logic        wr1,
   input  logic        addr_num0,
   input  logic        addr_num1,
   input  logic [15:0] byte_addr0,
   input  logic [15:0] byte_addr1,
   input  logic [7:0]  wdata0,
   input  logic [7:0]  wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [7:0]  rdata,
   output logic        i2c_start,
   output logic        wr_en,
   output logic        rd_en,
   output logic        addr_num,
   output logic [15:0] byte_addr,
   output logic [7:0]  wr_data,
   input  logic        i2c_end,
   input  logic [7:0]  rd_data
);

   localparam int TW = (TIMEOUT_MAX > 1) ? $clog2(TIMEOUT_MAX) : 1;
   localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_MAX - 1);
   localparam logic [WW-1:0] W_LAST = WW'(WAIT_MAX - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      WR_WAIT = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [WW-1:0] wcnt, wcnt_n;
   // last_owner doubles as the current owner while a transaction runs
   logic          last_owner, last_owner_n;

   logic          gnt0_n, gnt1_n, done0_n, done1_n, err0_n, err1_n;
   logic          start_n, wr_en_n, rd_en_n, addr_num_n;
   logic [15:0]   byte_addr_n;
   logic [7:0]    wr_data_n, rdata_n;

   logic          win_any, win;
   logic          win_wr, win_an;
   logic [15:0]   win_addr;
   logic [7:0]    win_data;

   always_comb begin
      win_any = req0 | req1;
      if (req0 && req1) begin
         win = ~last_owner;
      end else begin
         win = req1;
      end
      win_wr   = win ? wr1 : wr0;
      win_an   = win ? addr_num1 : addr_num0;
      win_addr = win ? byte_addr1 : byte_addr0;
      win_data = win ? wdata1 : wdata0;
   end

   always_comb begin
      state_n      = state;
      tcnt_n       = tcnt;
      wcnt_n       = wcnt;
      last_owner_n = last_owner;
      gnt0_n       = 1'b0;
      gnt1_n       = 1'b0;
      done0_n      = 1'b0;
      done1_n      = 1'b0;
      err0_n       = 1'b0;
      err1_n       = 1'b0;
      start_n      = 1'b0;
      wr_en_n      = wr_en;
      rd_en_n      = rd_en;
      addr_num_n   = addr_num;
      byte_addr_n  = byte_addr;
      wr_data_n    = wr_data;
      rdata_n      = rdata;
      unique case (state)
         IDLE: begin
            if (win_any) begin
               gnt0_n       = ~win;
               gnt1_n       = win;
               start_n      = 1'b1;
               wr_en_n      = win_wr;
               rd_en_n      = ~win_wr;
               addr_num_n   = win_an;
               byte_addr_n  = win_addr;
               wr_data_n    = win_data;
               last_owner_n = win;
               tcnt_n       = '0;
               state_n      = BUSY;
            end
         end
         BUSY: begin
            // completion outranks a timeout landing on the same edge
            if (i2c_end) begin
               done0_n = ~last_owner;
               done1_n = last_owner;
               if (rd_en) begin
                  rdata_n = rd_data;
               end
               wr_en_n = 1'b0;
               rd_en_n = 1'b0;
               tcnt_n  = '0;
               state_n = wr_en ? WR_WAIT : IDLE;
            end else if (tcnt == T_LAST) begin
               err0_n  = ~last_owner;
               err1_n  = last_owner;
               wr_en_n = 1'b0;
               rd_en_n = 1'b0;
               tcnt_n  = '0;
               state_n = WR_WAIT;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
         end
         WR_WAIT: begin
            if (wcnt == W_LAST) begin
               wcnt_n  = '0;
               state_n = IDLE;
            end else begin
               wcnt_n = wcnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         tcnt       <= '0;
         wcnt       <= '0;
         last_owner <= 1'b1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         i2c_start  <= 1'b0;
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         addr_num   <= 1'b0;
         byte_addr  <= '0;
         wr_data    <= '0;
         rdata      <= '0;
      end else begin
         state      <= state_n;
         tcnt       <= tcnt_n;
         wcnt       <= wcnt_n;
         last_owner <= last_owner_n;
         gnt0       <= gnt0_n;
         gnt1       <= gnt1_n;
         done0      <= done0_n;
         done1      <= done1_n;
         err0       <= err0_n;
         err1       <= err1_n;
         i2c_start  <= start_n;
         wr_en      <= wr_en_n;
         rd_en      <= rd_en_n;
         addr_num   <= addr_num_n;
         byte_addr  <= byte_addr_n;
         wr_data    <= wr_data_n;
         rdata      <= rdata_n;
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: vector table, directed corner sequences and
// random traffic against a timestamp-based reference model.
module tb_i2c_bus_arbiter;

   localparam int WAIT_MAX    = 10;
   localparam int TIMEOUT_MAX = 50;

   logic        sys_clk, sys_rst_n;
   logic        req0, req1, wr0, wr1, addr_num0, addr_num1;
   logic [15:0] byte_addr0, byte_addr1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1, err0, err1;
   logic [7:0]  rdata;
   logic        i2c_start, wr_en, rd_en, addr_num;
   logic [15:0] byte_addr;
   logic [7:0]  wr_data;
   logic        i2c_end;
   logic [7:0]  rd_data;

   i2c_bus_arbiter #(
      .WAIT_MAX(WAIT_MAX),
      .TIMEOUT_MAX(TIMEOUT_MAX)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr_num0(addr_num0), .addr_num1(addr_num1),
      .byte_addr0(byte_addr0), .byte_addr1(byte_addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .rdata(rdata),
      .i2c_start(i2c_start), .wr_en(wr_en), .rd_en(rd_en),
      .addr_num(addr_num), .byte_addr(byte_addr), .wr_data(wr_data),
      .i2c_end(i2c_end), .rd_data(rd_data)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_pass = 0;
   int n_total = 0;

   // reference model: owner plus absolute cycle stamps
   int   m_owner, m_start, m_guard, m_last, m_cyc;
   logic m_wr;
   logic e_gnt0, e_gnt1, e_done0, e_done1, e_err0, e_err1;
   logic e_start, e_wr, e_rd, e_an;
   logic [15:0] e_addr;
   logic [7:0]  e_wd, e_rdata;

   // master model controls
   int mdelay;
   bit mute, rnd;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic fail_now(input string name, input int budget);
      n_total++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
   endtask

   function automatic logic [63:0] dut_vec();
      return {22'd0, gnt0, gnt1, done0, done1, err0, err1, i2c_start,
              wr_en, rd_en, addr_num, byte_addr, wr_data, rdata};
   endfunction

   function automatic logic [63:0] exp_vec();
      return {22'd0, e_gnt0, e_gnt1, e_done0, e_done1, e_err0, e_err1,
              e_start, e_wr, e_rd, e_an, e_addr, e_wd, e_rdata};
   endfunction

   task automatic model_reset();
      m_owner = -1; m_start = 0; m_guard = 0; m_last = 1; m_cyc = 0;
      m_wr = 1'b0;
      {e_gnt0, e_gnt1, e_done0, e_done1, e_err0, e_err1} = '0;
      {e_start, e_wr, e_rd, e_an} = '0;
      e_addr = '0; e_wd = '0; e_rdata = '0;
   endtask

   task automatic model_update();
      int w;
      m_cyc++;
      {e_gnt0, e_gnt1, e_done0, e_done1, e_err0, e_err1, e_start} = '0;
      if (m_owner < 0) begin
         w = -1;
         if (m_cyc >= m_guard) begin
            if (req0 && req1) w = 1 - m_last;
            else if (req0) w = 0;
            else if (req1) w = 1;
         end
         if (w >= 0) begin
            m_owner = w; m_last = w; m_start = m_cyc; e_start = 1'b1;
            if (w == 0) begin
               e_gnt0 = 1'b1; m_wr = wr0; e_an = addr_num0;
               e_addr = byte_addr0; e_wd = wdata0;
            end else begin
               e_gnt1 = 1'b1; m_wr = wr1; e_an = addr_num1;
               e_addr = byte_addr1; e_wd = wdata1;
            end
            e_wr = m_wr; e_rd = !m_wr;
         end
      end else if (i2c_end) begin
         if (m_owner == 0) e_done0 = 1'b1; else e_done1 = 1'b1;
         if (!m_wr) e_rdata = rd_data;
         m_guard = m_wr ? m_cyc + WAIT_MAX + 1 : m_cyc + 1;
         m_owner = -1; e_wr = 1'b0; e_rd = 1'b0;
      end else if (m_cyc - m_start == TIMEOUT_MAX) begin
         if (m_owner == 0) e_err0 = 1'b1; else e_err1 = 1'b1;
         m_guard = m_cyc + WAIT_MAX + 1;
         m_owner = -1; e_wr = 1'b0; e_rd = 1'b0;
      end
   endtask

   // one clock: model follows the edge, outputs compared at the negedge
   task automatic step();
      if (!sys_rst_n) model_reset(); else model_update();
      @(negedge sys_clk);
      chk("cycle_outputs", dut_vec(), exp_vec());
      i2c_end = 1'b0;
      if (mdelay > 0) begin
         mdelay--;
         if (mdelay == 0) begin
            i2c_end = 1'b1;
            mdelay = -1;
         end
      end
      if (i2c_start) begin
         if (mute || (rnd && $urandom_range(0, 4) == 0)) mdelay = -1;
         else mdelay = rnd ? int'($urandom_range(1, 30)) : 19;
      end
      if (rnd && $urandom_range(0, 24) == 0) i2c_end = 1'b1;
   endtask

   task automatic wait_gnt(input int budget, output int who, output int n);
      who = -1; n = 0;
      while (who < 0 && n < budget) begin
         step();
         n++;
         if (gnt0) who = 0;
         else if (gnt1) who = 1;
      end
      if (who < 0) fail_now("gnt_wait", budget);
   endtask

   task automatic wait_end(input int budget, output int n,
                           output logic [3:0] code);
      code = '0; n = 0;
      while (code == 4'b0 && n < budget) begin
         step();
         n++;
         code = {err1, err0, done1, done0};
      end
      if (code == 4'b0) fail_now("end_wait", budget);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      #1;
      chk("reset_async", dut_vec(), 64'd0);
      model_reset();
      mdelay = -1;
      i2c_end = 1'b0;
      step();
      step();
      sys_rst_n = 1'b1;
   endtask

   typedef struct {
      logic r0, r1, w0, w1, n0, n1;
      logic [15:0] a0, a1;
      logic [7:0] d0, d1, rd;
      int g;
      logic xw, xn;
      logic [15:0] xa;
      logic [7:0] xd, xr;
   } vec_t;

   initial begin
      vec_t tbl[6];
      int who, n;
      logic [3:0] code;

      tbl[0] = '{1,0,1,0,0,0,16'h0005,16'h0000,8'hA5,8'h00,8'h00,
                 0,1,0,16'h0005,8'hA5,8'h00};
      tbl[1] = '{0,1,0,0,0,0,16'h0000,16'h0005,8'h00,8'h00,8'hA5,
                 1,0,0,16'h0005,8'h00,8'hA5};
      tbl[2] = '{1,1,0,1,1,0,16'h1234,16'h0042,8'h00,8'h11,8'h3C,
                 0,0,1,16'h1234,8'h00,8'h3C};
      tbl[3] = '{1,1,1,0,0,0,16'h00FF,16'h0042,8'h5A,8'h00,8'hC3,
                 1,0,0,16'h0042,8'h00,8'hC3};
      tbl[4] = '{1,1,1,0,0,0,16'h00FF,16'h0042,8'h5A,8'h00,8'h99,
                 0,1,0,16'h00FF,8'h5A,8'hC3};
      tbl[5] = '{1,0,0,0,1,0,16'h0777,16'h0000,8'h00,8'h00,8'h7E,
                 0,0,1,16'h0777,8'h00,8'h7E};

      {req0, req1, wr0, wr1, addr_num0, addr_num1} = '0;
      byte_addr0 = '0; byte_addr1 = '0; wdata0 = '0; wdata1 = '0;
      i2c_end = 1'b0; rd_data = '0;
      mdelay = -1; mute = 1'b0; rnd = 1'b0;
      model_reset();
      sys_rst_n = 1'b1;
      #2 sys_rst_n = 1'b0;
      #1 chk("reset_state", dut_vec(), 64'd0);
      @(negedge sys_clk);
      step();
      sys_rst_n = 1'b1;
      step();

      for (int i = 0; i < 6; i++) begin
         req0 = tbl[i].r0; req1 = tbl[i].r1;
         wr0 = tbl[i].w0; wr1 = tbl[i].w1;
         addr_num0 = tbl[i].n0; addr_num1 = tbl[i].n1;
         byte_addr0 = tbl[i].a0; byte_addr1 = tbl[i].a1;
         wdata0 = tbl[i].d0; wdata1 = tbl[i].d1;
         rd_data = tbl[i].rd;
         wait_gnt(40, who, n);
         req0 = 1'b0; req1 = 1'b0;
         chk("vec_gnt_who", who, tbl[i].g);
         chk("vec_start", i2c_start, 1'b1);
         chk("vec_wr_en", wr_en, tbl[i].xw);
         chk("vec_rd_en", rd_en, !tbl[i].xw);
         chk("vec_addr_num", addr_num, tbl[i].xn);
         chk("vec_byte_addr", byte_addr, tbl[i].xa);
         chk("vec_wr_data", wr_data, tbl[i].xd);
         wait_end(80, n, code);
         chk("vec_done_lat", n, 20);
         chk("vec_done_who", code, (tbl[i].g == 1) ? 4'b0010 : 4'b0001);
         chk("vec_rdata", rdata, tbl[i].xr);
         chk("vec_cmd_drop", {wr_en, rd_en}, 2'b00);
      end

      // tie: both held after reset alternate starting with client 0
      rd_data = 8'h5C;
      do_reset();
      req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
      for (int g = 0; g < 4; g++) begin
         wait_gnt(60, who, n);
         chk("tie_order", who, g % 2);
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_end(80, n, code);
      chk("tie_last_done", code, 4'b0010);

      // guard: read request during the post-write wait
      req0 = 1'b1; wr0 = 1'b1; byte_addr0 = 16'h0005; wdata0 = 8'hA5;
      wait_gnt(40, who, n);
      req0 = 1'b0;
      wait_end(80, n, code);
      chk("guard_done0", code, 4'b0001);
      step(); step(); step();
      req1 = 1'b1; wr1 = 1'b0;
      wait_gnt(40, who, n);
      req1 = 1'b0;
      chk("guard_who", who, 1);
      chk("guard_lat", n + 3, WAIT_MAX + 1);
      wait_end(80, n, code);
      chk("guard_rdata", rdata, 8'h5C);

      // timeout: master never answers
      mute = 1'b1;
      req0 = 1'b1; wr0 = 1'b1;
      wait_gnt(40, who, n);
      req0 = 1'b0;
      chk("to_who", who, 0);
      wait_end(120, n, code);
      chk("to_lat", n, TIMEOUT_MAX);
      chk("to_err0", code, 4'b0100);
      chk("to_wr_drop", wr_en, 1'b0);
      mute = 1'b0;
      req1 = 1'b1; wr1 = 1'b0;
      wait_gnt(40, who, n);
      req1 = 1'b0;
      chk("to_guard_lat", n, WAIT_MAX + 1);
      wait_end(80, n, code);

      // reset mid-transaction, then a tie goes to client 0
      req0 = 1'b1; wr0 = 1'b1;
      wait_gnt(40, who, n);
      req0 = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("busy_before_rst", wr_en, 1'b1);
      do_reset();
      req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
      wait_gnt(40, who, n);
      req0 = 1'b0; req1 = 1'b0;
      chk("rst_tie_who", who, 0);
      wait_end(80, n, code);

      // random traffic with stray i2c_end pulses and silent transfers
      rnd = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            req0 = 1'($urandom_range(0, 1)); wr0 = 1'($urandom_range(0, 1));
            addr_num0 = 1'($urandom_range(0, 1));
            byte_addr0 = 16'($urandom); wdata0 = 8'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            req1 = 1'($urandom_range(0, 1)); wr1 = 1'($urandom_range(0, 1));
            addr_num1 = 1'($urandom_range(0, 1));
            byte_addr1 = 16'($urandom); wdata1 = 8'($urandom);
         end
         rd_data = 8'($urandom);
         step();
      end
      rnd = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 100; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one byte-level I2C master (i2c_ctrl) between two single-byte requesters, for example the key-driven EEPROM read/write sequencer and a second client such as a config loader.
- Round-robin arbitration; latches the winning command and drives the master's start/command interface.
- Routes completion, read data and timeout errors back to the owner.
- After every write, enforces a global write-cycle guard (EEPROM tWR) before it issues the next transaction.

Parameters:
- WAIT_MAX, 250_000: post-write guard length in sys_clk cycles (5 ms at 50 MHz); benches override it to a small value.
- TIMEOUT_MAX, 1_000_000: maximum sys_clk cycles in BUSY before the transaction is aborted.

Ports:
- sys_clk  input  1  system clock, 50 MHz
- sys_rst_n  input  1  asynchronous active-low reset
- req0 / req1  input  1  client request, level, sampled only in IDLE
- wr0 / wr1  input  1  1 = write, 0 = random read
- addr_num0 / addr_num1  input  1  0 = 8-bit byte address, 1 = 16-bit byte address
- byte_addr0 / byte_addr1  input  16  EEPROM byte address
- wdata0 / wdata1  input  8  write data
- gnt0 / gnt1  output  1  one-cycle pulse: command accepted
- done0 / done1  output  1  one-cycle pulse: transaction complete
- err0 / err1  output  1  one-cycle pulse: transaction timed out
- rdata  output  8  last read byte, shared, valid when done of a read pulses
- i2c_start  output  1  one-cycle start pulse to the master
- wr_en  output  1  write command level to the master
- rd_en  output  1  read command level to the master
- addr_num  output  1  latched address width
- byte_addr  output  16  latched address
- wr_data  output  8  latched write data
- i2c_end  input  1  one-sys_clk-cycle completion pulse from the master
- rd_data  input  8  read byte from the master, valid with i2c_end

Behaviour:
- Reset (asynchronous, any state, mid-transaction included):
  - State goes to IDLE; all outputs, the counters and rdata clear to 0.
  - last_owner is set to 1, so client 0 wins the first tie.
- States: IDLE, BUSY, WR_WAIT.
- IDLE:
  - If neither request is active, stay in IDLE.
  - If exactly one request is active, that client wins.
  - If both are active, the client other than last_owner wins.
  - At the sampling edge, the following registered actions happen together:
    - gnt of the winner = 1.
    - i2c_start = 1.
    - wr_en = winner's wr, rd_en = the inverse of it.
    - addr_num, byte_addr and wr_data are latched from the winner.
    - last_owner = winner.
    - State goes to BUSY.
  - Latency: request seen at edge k gives gnt and i2c_start high for exactly the cycle after edge k.
- BUSY:
  - gnt and i2c_start return to 0 at the next edge.
  - wr_en/rd_en and the latched command hold steady until the transaction ends.
  - Client inputs are ignored; a client may drop or change req after gnt.
  - The timeout counter increments every cycle.
  - i2c_end sampled at edge m:
    - wr_en and rd_en go to 0.
    - done of the owner = 1 for one cycle.
    - If the transaction was a read, rdata takes rd_data at the same edge.
    - Timeout counter clears.
    - Next state is WR_WAIT for a write, IDLE for a read.
  - Timeout counter reaching TIMEOUT_MAX-1 with no i2c_end:
    - err of the owner = 1 for one cycle; done is not pulsed.
    - wr_en and rd_en go to 0; counter clears.
    - Next state is WR_WAIT, because the device may be mid-write.
  - i2c_end and timeout on the same edge: i2c_end wins.
- WR_WAIT:
  - Guard counter counts 0 to WAIT_MAX-1, then clears; state goes to IDLE.
  - Requests stay pending and are not granted during the guard, whichever client asks.
- i2c_end in IDLE or WR_WAIT is ignored; no outputs change.
- gnt, done and err are mutually exclusive per client and never asserted for both clients in the same cycle.
- Counters are sized to hold their MAX-1 value; the timeout counter is 20 bits at the defaults.

Test Plan (WAIT_MAX=10, TIMEOUT_MAX=50, master model returns i2c_end 20 cycles after i2c_start):
- Write: req0, wr0=1, byte_addr0=16'h0005, wdata0=8'hA5 -> gnt0 and i2c_start pulse one cycle later; wr_en=1 with byte_addr=0005 and wr_data=A5 held; done0 pulses after i2c_end; no new grant for 10 cycles.
- Read: req1, wr1=0, byte_addr1=16'h0005; model returns rd_data=8'hA5 -> rd_en=1, rdata=8'hA5 when done1 pulses; return to IDLE with no guard.
- Tie: req0 and req1 held high continuously after reset -> grants in the order gnt0, gnt1, gnt0, gnt1; no back-to-back grant to the same client.
- Guard: req1 raised during WR_WAIT after a client-0 write -> gnt1 appears exactly WAIT_MAX cycles after done0's cycle, plus one.
- Timeout: model never returns i2c_end -> err0 pulse 50 cycles after entering BUSY; done0 never pulses; wr_en falls; WR_WAIT entered.
- Reset mid-BUSY: deassert sys_rst_n -> outputs go to 0 immediately; after release, req1 and req0 together -> gnt0 first.
